clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator.
- Each of NUM_CH channels divides clk_in by its own divisor D. Each channel produces a near-50% square wave (clk_out) and a one-cycle enable pulse per period (tick_out).
- Successor to the fixed single-output divider: adds a divisor write port, per-channel enable, glitch-free divisor changes and exact divide-by-D for any D >= 2, odd or even.
- Sits between the board clock and the KPN process modules that need slow strobes or slow clocks.

Parameters:
- NUM_CH, 4, number of independent channels (>= 1).
- DIV_W, 26, width of divisor and counter.
- DEFAULT_DIV, 25_000_000, reset divisor of every channel (2 <= DEFAULT_DIV < 2^DIV_W).
- CH_W, $clog2(NUM_CH) (minimum 1), width of cfg_ch; derived localparam.

Ports:
- clk_in  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
- cfg_we  input  1  divisor write strobe, one cycle per write.
- cfg_ch  input  CH_W  target channel of the write.
- cfg_div  input  DIV_W  new divisor D (period in clk_in cycles).
- ch_en  input  NUM_CH  per-channel run enable, level sensitive.
- clk_out  output  NUM_CH  divided square wave per channel.
- tick_out  output  NUM_CH  one-cycle pulse per channel, high in the last cycle of each period.
- cfg_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Per-channel state:
  - cnt[DIV_W]: phase counter.
  - div[DIV_W]: active divisor.
  - shadow[DIV_W]: staged divisor.
  - pend: a staged divisor is waiting.
- Reset (rst_n low at the clock edge):
  - cnt=0, div=shadow=DEFAULT_DIV, pend=0.
  - clk_out=0, tick_out=0, cfg_err=0.
  - Reset applied mid-period aborts the period immediately and discards any pending write.
- Running (ch_en[i]=1):
  - cnt counts 0..div-1, then wraps to 0.
  - Output period is exactly div cycles.
- Outputs are registers, computed from the next counter value so they align with cnt:
  - clk_out[i]=1 iff cnt >= floor(div/2). This gives floor(D/2) cycles low, then ceil(D/2) cycles high.
  - tick_out[i]=1 iff cnt == div-1.
- Disabled (ch_en[i]=0):
  - cnt held at 0; clk_out[i]=0; tick_out[i]=0.
  - On re-enable, the first enabled cycle has cnt=0, so a full period elapses before the first tick.
- Divisor write validation:
  - A write is rejected when cfg_ch >= NUM_CH, or when cfg_div < 2.
  - On rejection: cfg_err=1 in the next cycle, and no state changes.
  - Every other write is accepted, with cfg_err=0.
- Accepted write, target channel enabled:
  - shadow <= cfg_div, pend <= 1.
  - At the next wrap (cycle with cnt==div-1 that advances to 0): div <= shadow, pend <= 0.
  - The current period always completes with the old divisor, so there is no runt pulse.
- Accepted write in the same cycle as the wrap: cfg_div is loaded directly into div at that wrap and governs the very next period; pend stays 0.
- Multiple writes before a wrap: the last one wins.
- Accepted write, target channel disabled: div <= cfg_div immediately; cnt stays 0.
- Write in the same cycle as an ch_en rising edge: treated as the disabled case, so the new divisor governs the first period.
- Channels are fully independent; a write to one channel never disturbs another.
- Latency: write to effect is at most the remainder of the current period.
- No illegal counter state is reachable: div only changes at cnt=0 boundaries.

Decomposition:
- Package clock_divider_pkg:
  - DIV_W_DEFAULT and DEFAULT_DIV constants.
  - MIN_DIV=2 constant.
  - Function half_div(D)=D>>1.
- Sub-module clock_divider_channel:
  - Holds cnt/div/shadow/pend and the output registers for one channel.
  - Inputs: wr (decoded, already validated), wr_div, en.
  - The top level is a generate loop of NUM_CH instances plus write decode and validation.

Test Plan:
(Bench overrides DIV_W=8, DEFAULT_DIV=6, NUM_CH=4.)
1. Reset release, all ch_en=1 -> each channel clk_out pattern 0,0,0,1,1,1 repeating; tick_out high every 6th cycle, at cnt=5.
2. Write ch1 D=5 mid-period (cnt=2) -> ch1 finishes its 6-cycle period, then runs period 5 (low 2, high 3); ch0, ch2, ch3 unchanged.
3. Write D=1 to ch2, then cfg_ch=... is not tested here; write cfg_ch=3 D=0 -> cfg_err pulses one cycle each; ch2 and ch3 divisors stay 6.
4. Write ch0 D=7 exactly on the cnt=5 cycle -> the next ch0 period is 7 cycles (low 3, high 4), with no intermediate period.
5. Deassert ch_en[3] at cnt=4, write D=3, re-enable -> clk_out[3] and tick_out[3] stay 0 while disabled; after re-enable: 0,1,1 with tick at the 3rd cycle.
6. rst_n low for 1 cycle while ch1 has a pending write (D=9) -> all outputs 0 in the reset cycle; ch1 resumes with D=6 and the pending value is lost.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// ============================================================================
// Module   : clock_divider_pkg
// Brief    : Shared constants and helpers for the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_divider_pkg;

  localparam int DIV_W_DEFAULT = 26;
  localparam int DEFAULT_DIV   = 25_000_000;
  localparam int MIN_DIV       = 2;

  // Length of the low phase of a period of d cycles.
  function automatic logic [31:0] half_div(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_channel.sv
// ============================================================================
// Module   : clock_divider_channel
// Brief    : One divider channel: phase counter, active/staged divisor and
//            registered square-wave and tick outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_channel #(
  parameter int DIV_W       = clock_divider_pkg::DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o
);

  import clock_divider_pkg::*;

  localparam logic [DIV_W-1:0] c_RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             en_prev_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             w_wrap;
  logic             w_idle;

  // A channel that was off last cycle sits at cnt=0, so a divisor change is safe.
  assign w_idle = ~en_i | ~en_prev_q;
  assign w_wrap = en_i & (cnt_q == div_q - c_ONE);

  always_comb begin
    cnt_d    = '0;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;

    if (w_idle) begin
      if (pend_q) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
      end
      if (wr_i) begin
        div_d  = wr_div_i;
        pend_d = 1'b0;
      end
    end else if (w_wrap) begin
      div_d  = wr_i ? wr_div_i : (pend_q ? shadow_q : div_q);
      pend_d = 1'b0;
    end else if (wr_i) begin
      shadow_d = wr_div_i;
      pend_d   = 1'b1;
    end

    if (en_i && !w_wrap) begin
      cnt_d = cnt_q + c_ONE;
    end

    clk_d  = en_i & (cnt_d >= DIV_W'(half_div(32'(div_d))));
    tick_d = en_i & (cnt_d == div_d - c_ONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= c_RST_DIV;
      shadow_q  <= c_RST_DIV;
      pend_q    <= 1'b0;
      en_prev_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      en_prev_q <= en_i;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module   : clock_divider_prog
// Brief    : Multi-channel runtime-programmable clock divider / tick generator
//            with validated divisor write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = clock_divider_pkg::DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = clock_divider_pkg::DEFAULT_DIV,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out,
  output logic              cfg_err
);

  import clock_divider_pkg::*;

  logic w_ch_ok;
  logic w_div_ok;
  logic w_accept;
  logic cfg_err_q, cfg_err_d;

  assign w_ch_ok   = 32'(cfg_ch) < 32'(NUM_CH);
  assign w_div_ok  = cfg_div >= DIV_W'(MIN_DIV);
  assign w_accept  = cfg_we & w_ch_ok & w_div_ok;
  assign cfg_err_d = cfg_we & ~(w_ch_ok & w_div_ok);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk_in),
      .rst_ni   (rst_n),
      .en_i     (ch_en[g]),
      .wr_i     (w_accept && (cfg_ch == CH_W'(g))),
      .wr_div_i (cfg_div),
      .clk_o    (clk_out[g]),
      .tick_o   (tick_out[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// Module   : tb_clock_divider_prog
// Brief    : Directed scenarios plus randomized traffic against a period-level
//            reference model of clock_divider_prog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int DEF    = 6;
  localparam int CH_W   = 2;

  logic              clk_in  = 1'b0;
  logic              rst_n   = 1'b0;
  logic              cfg_we  = 1'b0;
  logic [CH_W-1:0]   cfg_ch  = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] ch_en   = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick_out;
  logic              cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: position inside the current period, period length,
  // staged period (-1 = none) and whether the channel ran last cycle.
  int m_pos [NUM_CH];
  int m_per [NUM_CH];
  int m_stg [NUM_CH];
  bit m_was [NUM_CH];
  logic [NUM_CH-1:0] e_clk;
  logic [NUM_CH-1:0] e_tick;
  logic              e_err;

  clock_divider_prog #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .ch_en    (ch_en),
    .clk_out  (clk_out),
    .tick_out (tick_out),
    .cfg_err  (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit bad;
    bit w;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pos[i] = 0; m_per[i] = DEF; m_stg[i] = -1; m_was[i] = 0;
      end
      e_clk = '0; e_tick = '0; e_err = 1'b0;
      return;
    end
    bad   = cfg_we && ((int'(cfg_ch) >= NUM_CH) || (int'(cfg_div) < 2));
    e_err = bad;
    for (int i = 0; i < NUM_CH; i++) begin
      w = cfg_we && !bad && (int'(cfg_ch) == i);
      if (!ch_en[i] || !m_was[i]) begin
        // Stopped or just starting: the period has not begun, new value applies now.
        if (m_stg[i] >= 0) m_per[i] = m_stg[i];
        m_stg[i] = -1;
        if (w) m_per[i] = int'(cfg_div);
        m_pos[i] = ch_en[i] ? 1 : 0;
      end else if (m_pos[i] == m_per[i] - 1) begin
        m_pos[i] = 0;
        if (w) m_per[i] = int'(cfg_div);
        else if (m_stg[i] >= 0) m_per[i] = m_stg[i];
        m_stg[i] = -1;
      end else begin
        m_pos[i]++;
        if (w) m_stg[i] = int'(cfg_div);
      end
      m_was[i]  = ch_en[i];
      e_clk[i]  = ch_en[i] && (m_pos[i] >= m_per[i] / 2);
      e_tick[i] = ch_en[i] && (m_pos[i] == m_per[i] - 1);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("clk_out", clk_out, e_clk);
    chk("tick_out", tick_out, e_tick);
    chk("cfg_err", cfg_err, e_err);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(d);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic wait_pos(input int ch, input int p, input string tag);
    int k;
    k = 0;
    while (m_pos[ch] != p && k < 60) begin
      step();
      k++;
    end
    chk(tag, 32'(m_pos[ch]), 32'(p));
  endtask

  logic [5:0] pat_clk;
  logic [5:0] pat_tick;

  initial begin
    // 1: reset and default divide-by-6
    ch_en = '1;
    rst_n = 1'b0;
    steps(2);
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick_out, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      pat_clk[5-k]  = clk_out[0];
      pat_tick[5-k] = tick_out[0];
    end
    chk("div6_clk_pattern", pat_clk, 6'b001110);
    chk("div6_tick_pattern", pat_tick, 6'b000010);
    steps(6);

    // 2: ch1 -> 5 mid-period
    wait_pos(1, 2, "wait_ch1_pos2");
    wr(1, 5);
    steps(16);

    // 3: rejected writes
    wr(2, 1);
    chk("err_pulse_d1", cfg_err, 1);
    wr(3, 0);
    chk("err_pulse_d0", cfg_err, 1);
    step();
    chk("err_clear", cfg_err, 0);
    steps(12);

    // 4: ch0 -> 7 exactly on the wrap cycle
    wait_pos(0, 5, "wait_ch0_pos5");
    wr(0, 7);
    chk("ch0_wrap_load", 32'(m_per[0]), 7);
    steps(16);

    // 5: disable ch3, reprogram, re-enable
    wait_pos(3, 4, "wait_ch3_pos4");
    ch_en[3] = 1'b0;
    steps(3);
    wr(3, 3);
    steps(2);
    ch_en[3] = 1'b1;
    steps(9);

    // 6: reset while ch1 holds a staged value
    wait_pos(1, 1, "wait_ch1_pos1");
    wr(1, 9);
    rst_n = 1'b0;
    step();
    chk("rst_mid_clk", clk_out, 0);
    chk("rst_mid_tick", tick_out, 0);
    rst_n = 1'b1;
    steps(14);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) begin
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'($urandom_range(0, NUM_CH - 1));
        cfg_div = DIV_W'($urandom_range(0, 12));
      end else begin
        cfg_we = 1'b0;
      end
      step();
    end
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    steps(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
